// File: rtl/fifo_lane_if.sv
// Lane bus between the byte source/mux stage and one fifo_lane instance.
// The err field exists only when FIFO_ERR_EN is defined.
interface fifo_lane_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) ();
  logic [WIDTH-1:0]         dataIn;
  logic                     validIn;
  logic                     pop;
  logic [WIDTH-1:0]         dataOut;
  logic                     validOut;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
`ifdef FIFO_ERR_EN
  logic [1:0]               err;
`endif

  modport master (
    output dataIn, validIn, pop,
    input  dataOut, validOut, full, empty, almost_full, almost_empty, count
`ifdef FIFO_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  dataIn, validIn, pop,
    output dataOut, validOut, full, empty, almost_full, almost_empty, count
`ifdef FIFO_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/fifo_lane.sv
// Single-clock per-lane input FIFO feeding one input of the L1 4:1 byte mux.
// Define FIFO_ERR_EN to add sticky overflow/underflow bits on bus.err.
module fifo_lane #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input logic        clk,
  input logic        reset,
  fifo_lane_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic             full, empty, pop_ok, push_ok;
`ifdef FIFO_ERR_EN
  logic [1:0]       err_q, err_d;
`endif

  // A pop on a full FIFO frees the slot the concurrent push needs.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    pop_ok  = bus.pop && !empty;
    push_ok = bus.validIn && (!full || pop_ok);

    wr_ptr_d = wr_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    rd_ptr_d    = rd_ptr_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    if (pop_ok) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

`ifdef FIFO_ERR_EN
    err_d = err_q | {bus.validIn && full && !bus.pop, bus.pop && empty};
`endif
  end

  // Storage has no reset so it can map onto RAM; reset only rewinds pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem_q[wr_ptr_q] <= bus.dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
`ifdef FIFO_ERR_EN
      err_q       <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
`ifdef FIFO_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.dataOut      = data_out_q;
  assign bus.validOut     = valid_out_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
`ifdef FIFO_ERR_EN
  assign bus.err          = err_q;
`endif
endmodule
